// File: rtl/mfp_irq_ack_if.sv
// Bus between the MFP interrupt acknowledge block and its CPU/pending-bank side.
interface mfp_irq_ack_if;
   logic [15:0] ipend;
   logic [15:0] imask;
   logic [7:0]  vr;
   logic        iei_n;
   logic        iack;
   logic        isr_we;
   logic [15:0] isr_wdata;
   logic        irq_n;
   logic        ieo_n;
   logic        vec_valid;
   logic [7:0]  vector;
   logic [15:0] clr_pend;
   logic [15:0] isr;

   modport slave (
      input  ipend, imask, vr, iei_n, iack, isr_we, isr_wdata,
      output irq_n, ieo_n, vec_valid, vector, clr_pend, isr
   );

   modport master (
      output ipend, imask, vr, iei_n, iack, isr_we, isr_wdata,
      input  irq_n, ieo_n, vec_valid, vector, clr_pend, isr
   );
endinterface

// File: rtl/mfp_irq_ack.sv
// 16-channel MFP interrupt priority arbiter with daisy-chain acknowledge,
// vector generation, pending-clear pulse and in-service register.
module mfp_irq_ack (
   input logic          clk,
   input logic          reset,
   mfp_irq_ack_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DRIVE, PASS, WAIT} state_t;

   state_t      state, state_nxt;
   logic [15:0] elig;
   logic        win_any;
   logic [3:0]  win;
   logic        irq_n_nxt, ieo_n_nxt, vec_valid_nxt, set_isr;
   logic [7:0]  vector_nxt;
   logic [15:0] clr_nxt, isr_nxt;
   logic        unused_vr;

   assign unused_vr = ^bus.vr[2:0];

   // An in-service bit masks its own channel and every lower one.
   always_comb begin
      logic blk;
      blk  = 1'b0;
      elig = '0;
      for (int c = 15; c >= 0; c--) begin
         blk     = blk | bus.isr[c];
         elig[c] = bus.ipend[c] & bus.imask[c] & ~blk;
      end
      win_any = |elig;
      win     = '0;
      for (int c = 0; c < 16; c++)
         if (elig[c]) win = 4'(c);
   end

   always_comb begin
      state_nxt     = state;
      irq_n_nxt     = 1'b1;
      ieo_n_nxt     = 1'b1;
      vec_valid_nxt = 1'b0;
      vector_nxt    = bus.vector;
      clr_nxt       = '0;
      set_isr       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.iack) begin
               if (!bus.iei_n && win_any) begin
                  state_nxt     = DRIVE;
                  vec_valid_nxt = 1'b1;
                  vector_nxt    = {bus.vr[7:4], win};
                  clr_nxt[win]  = 1'b1;
                  set_isr       = bus.vr[3];
               end else begin
                  state_nxt = PASS;
                  ieo_n_nxt = 1'b0;
               end
            end else begin
               irq_n_nxt = ~(win_any & ~bus.iei_n);
            end
         end
         DRIVE: begin
            if (!bus.iack) state_nxt = WAIT;
            else           vec_valid_nxt = 1'b1;
         end
         PASS: begin
            if (!bus.iack) state_nxt = WAIT;
            else           ieo_n_nxt = 1'b0;
         end
         WAIT: begin
            // Pending clear has landed by now, so re-arbitrate for the first IDLE cycle.
            state_nxt = IDLE;
            irq_n_nxt = ~(win_any & ~bus.iei_n);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The acknowledge set beats a simultaneous CPU clear of the same bit.
   always_comb begin
      isr_nxt = bus.isr;
      if (bus.isr_we) isr_nxt = isr_nxt & bus.isr_wdata;
      if (set_isr)    isr_nxt[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bus.irq_n     <= 1'b1;
         bus.ieo_n     <= 1'b1;
         bus.vec_valid <= 1'b0;
         bus.vector    <= '0;
         bus.clr_pend  <= '0;
         bus.isr       <= '0;
      end else begin
         state         <= state_nxt;
         bus.irq_n     <= irq_n_nxt;
         bus.ieo_n     <= ieo_n_nxt;
         bus.vec_valid <= vec_valid_nxt;
         bus.vector    <= vector_nxt;
         bus.clr_pend  <= clr_nxt;
         bus.isr       <= bus.vr[3] ? isr_nxt : '0;
      end
   end

endmodule

// File: doc/mfp_irq_ack.md
MFP_IRQ_ACK -- requirements
Module: mfp_irq_ack

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16 channels, 8-bit vector.
REQ-002 clk  input  1  system clock (32 MHz); all state SHALL change on its rising edge only.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 ipend  input  16  interrupt-pending bits from the pending flip-flop bank; bit 15 is the highest priority.
REQ-005 imask  input  16  interrupt mask; 1 = channel may request.
REQ-006 vr  input  8  vector register; [7:4] vector base, [3] S (software end-of-interrupt mode), [2:0] unused.
REQ-007 iei_n  input  1  daisy-chain enable in, active-low.
REQ-008 iack  input  1  CPU interrupt-acknowledge level, held high for the whole acknowledge cycle.
REQ-009 isr_we  input  1  CPU write strobe to the in-service register.
REQ-010 isr_wdata  input  16  CPU in-service write data; zero bits clear, one bits leave unchanged.
REQ-011 irq_n  output  1  interrupt request to CPU, active-low, registered.
REQ-012 ieo_n  output  1  daisy-chain enable out, active-low, registered.
REQ-013 vec_valid  output  1  vector on vector is valid, registered.
REQ-014 vector  output  8  interrupt vector, registered.
REQ-015 clr_pend  output  16  one-hot, one-cycle pulse that clears the acknowledged pending bit; feeds the pending bank's reset input.
REQ-016 isr  output  16  in-service register.

Function
REQ-017 Eligibility: channel c SHALL be eligible when ipend[c] & imask[c] and no isr bit at index >= c is set.
REQ-018 The winner SHALL be the highest-index eligible channel; win_any SHALL be set when any channel is eligible.
REQ-019 The FSM SHALL have four states: IDLE, DRIVE, PASS, WAIT.
REQ-020 IDLE: irq_n SHALL equal ~(win_any & ~iei_n), registered with one cycle of latency; vec_valid = 0; ieo_n = 1.
REQ-021 IDLE -> DRIVE: this transition SHALL occur on the first cycle iack is sampled high with iei_n low and win_any = 1; the winner index c SHALL be latched in that cycle.
REQ-022 On entering DRIVE (the cycle after iack is first sampled high) the block SHALL set vec_valid = 1 and vector = {vr[7:4], c} and SHALL pulse clr_pend[c] for exactly that cycle; if vr[3] = 1, isr[c] SHALL be set in that same cycle.
REQ-023 IDLE -> PASS: this transition SHALL occur on the first cycle iack is sampled high with iei_n high or win_any = 0; in PASS, ieo_n SHALL be 0 and vec_valid SHALL be 0.
REQ-024 DRIVE and PASS SHALL hold until iack is sampled low, then go to WAIT; in DRIVE, vector and vec_valid SHALL stay constant regardless of changes on ipend, imask or vr.
REQ-025 WAIT SHALL last exactly one cycle with vec_valid = 0, ieo_n = 1 and irq_n = 1, then go to IDLE; this cycle lets the pending clear propagate before re-arbitration.
REQ-026 irq_n SHALL be 1 in DRIVE, PASS and WAIT.
REQ-027 isr update: on isr_we, isr SHALL become isr & isr_wdata; if that write coincides with the set in REQ-022, the set SHALL win for bit c.
REQ-028 When vr[3] = 0, isr SHALL be held at all-zero; this clears every in-service bit in the cycle after S is cleared.
REQ-029 If iack falls in the same cycle as DRIVE entry, the DRIVE outputs SHALL still be presented for one cycle before WAIT.
REQ-030 Each acknowledge cycle SHALL produce at most one clr_pend pulse; clr_pend SHALL be all-zero in every other cycle.

Reset
REQ-031 While reset is high the block SHALL force state = IDLE, irq_n = 1, ieo_n = 1, vec_valid = 0, vector = 0x00, clr_pend = 0 and isr = 0.
REQ-032 Reset asserted mid-acknowledge SHALL abort without any clr_pend pulse in the reset cycle.
REQ-033 After reset deasserts, irq_n SHALL reflect eligibility starting from the second cycle.

Verification
REQ-034 ipend=0x0010, imask=0xFFFF, vr=0x40, iei_n=0, raise iack -> irq_n=0 beforehand; the next cycle gives vec_valid=1, vector=0x44 and clr_pend=0x0010 for one cycle; isr stays 0.
REQ-035 ipend=0x8001, vr=0x48, acknowledge -> vector=0x4F and isr=0x8000; on a second acknowledge while bit 0 is still pending, irq_n stays 1 (blocked by isr[15]); an isr write of 0x7FFF then drives irq_n low, and acknowledging gives vector=0x40.
REQ-036 iei_n=1 with ipend=0x0004 and iack high -> PASS with ieo_n=0, vec_valid=0 and no clr_pend; when iack drops, ieo_n=1 after WAIT.
REQ-037 In DRIVE with vector 0x44, change ipend to 0x8000 -> vector stays 0x44 until iack falls; after WAIT a new request with irq_n=0 appears.
REQ-038 vr=0x48 with isr=0x0100, then write vr=0x40 -> isr=0x0000 the next cycle.
REQ-039 Assert reset during DRIVE -> all outputs return to reset values the next cycle, with no clr_pend pulse.
